// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor type, hall FSM states, direction codes and a popcount helper.
package elevator_pkg;

    localparam int NUM_FLOORS_MAX = 8;

    typedef logic [2:0] floor_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} hall_fsm_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic [3:0] count_bits(input logic [NUM_FLOORS_MAX-1:0] v);
        count_bits = '0;
        for (int i = 0; i < NUM_FLOORS_MAX; i++)
            count_bits += {3'b000, v[i]};
    endfunction

endpackage

// File: rtl/hall_call_rr_arbiter.sv
// hall_call_rr_arbiter: combinational round-robin pick, searching from pointer+1 and wrapping.
module hall_call_rr_arbiter
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 7
) (
    input  logic [NUM_FLOORS-1:0] request,
    input  floor_t                pointer,
    output logic                  grant_valid,
    output floor_t                grant_floor
);

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant_valid = |request;
        grant_floor = '0;
        for (int i = NUM_FLOORS; i >= 1; i--)
            if (request[floor_t'((int'(pointer) + i) % NUM_FLOORS)])
                grant_floor = floor_t'((int'(pointer) + i) % NUM_FLOORS);
    end

endmodule

// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall buttons, drives lamps and issues each new call once
// to the car as a one-cycle hall_r_nwr strobe; retires calls the car has serviced.
module hall_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS     = 7,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] hall_up_btn,
    input  logic [NUM_FLOORS-1:0] hall_dn_btn,
    input  floor_t                car_current_floor,
    input  logic                  car_dir,
    input  logic                  car_queue_empty,
    output logic                  hall_r_nwr,
    output floor_t                hall_request_floor,
    output logic [NUM_FLOORS-1:0] hall_up_lamp,
    output logic [NUM_FLOORS-1:0] hall_dn_lamp,
    output logic [3:0]            pending_count
);

    logic [NUM_FLOORS-1:0] up_pend, dn_pend, up_iss, dn_iss;
    logic [NUM_FLOORS-1:0] up_pend_n, dn_pend_n, up_iss_n, dn_iss_n;
    logic [NUM_FLOORS-1:0] req, at_car, sel_oh, up_ret, dn_ret, up_set, dn_set;
    hall_fsm_t             state, state_n;
    floor_t                ptr, sel, grant_floor;
    logic                  grant_valid, issuing;
    logic [3:0]            cnt;

    assign req          = (up_pend & ~up_iss) | (dn_pend & ~dn_iss);
    assign issuing      = state == ISSUE;
    assign hall_up_lamp = up_pend;
    assign hall_dn_lamp = dn_pend;

    hall_call_rr_arbiter #(.NUM_FLOORS(NUM_FLOORS)) u_arb (
        .request     (req),
        .pointer     (ptr),
        .grant_valid (grant_valid),
        .grant_floor (grant_floor)
    );

    // A car floor outside 0..NUM_FLOORS-1 matches no bit, so it retires nothing.
    always_comb begin
        at_car = '0;
        sel_oh = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            at_car[f] = car_current_floor == floor_t'(f);
            sel_oh[f] = sel == floor_t'(f);
        end
    end

    // Press wins over retire: pend is re-set while iss clears, forcing a re-issue.
    always_comb begin
        up_ret    = at_car & up_iss & {NUM_FLOORS{car_dir == DIR_UP || car_queue_empty}};
        dn_ret    = at_car & dn_iss & {NUM_FLOORS{car_dir == DIR_DN || car_queue_empty}};
        up_set    = {NUM_FLOORS{issuing}} & sel_oh & up_pend & ~up_iss;
        dn_set    = {NUM_FLOORS{issuing}} & sel_oh & dn_pend & ~dn_iss;
        up_pend_n = (up_pend & ~up_ret) | hall_up_btn;
        dn_pend_n = (dn_pend & ~dn_ret) | hall_dn_btn;
        up_iss_n  = (up_iss & ~up_ret) | up_set;
        dn_iss_n  = (dn_iss & ~dn_ret) | dn_set;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = grant_valid ? ISSUE : IDLE;
            ISSUE:   state_n = HOLDOFF;
            HOLDOFF: state_n = (cnt <= 4'd1) ? IDLE : HOLDOFF;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_pend            <= '0;
            dn_pend            <= '0;
            up_iss             <= '0;
            dn_iss             <= '0;
            state              <= IDLE;
            ptr                <= '0;
            sel                <= '0;
            cnt                <= '0;
            hall_r_nwr         <= 1'b0;
            hall_request_floor <= '0;
            pending_count      <= '0;
        end else begin
            up_pend       <= up_pend_n;
            dn_pend       <= dn_pend_n;
            up_iss        <= up_iss_n;
            dn_iss        <= dn_iss_n;
            state         <= state_n;
            hall_r_nwr    <= issuing;
            pending_count <= count_bits(NUM_FLOORS_MAX'(up_pend_n)) + count_bits(NUM_FLOORS_MAX'(dn_pend_n));
            if (state == IDLE && grant_valid)
                sel <= grant_floor;
            if (issuing) begin
                hall_request_floor <= sel;
                ptr                <= sel;
                cnt                <= 4'(HOLDOFF_CYCLES);
            end else if (state == HOLDOFF) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// tb_hall_call_dispatcher: directed scenarios with hand-computed strobe timing, lamps and counts.
module tb_hall_call_dispatcher;
    import elevator_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] hall_up_btn = '0;
    logic [6:0] hall_dn_btn = '0;
    floor_t     car_current_floor = 3'd7;
    logic       car_dir = 1'b0;
    logic       car_queue_empty = 1'b0;
    logic       hall_r_nwr;
    floor_t     hall_request_floor;
    logic [6:0] hall_up_lamp, hall_dn_lamp;
    logic [3:0] pending_count;

    int n_cmp = 0;
    int n_bad = 0;
    int st_t[$];
    int st_f[$];

    hall_call_dispatcher #(.NUM_FLOORS(7), .HOLDOFF_CYCLES(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .hall_up_btn        (hall_up_btn),
        .hall_dn_btn        (hall_dn_btn),
        .car_current_floor  (car_current_floor),
        .car_dir            (car_dir),
        .car_queue_empty    (car_queue_empty),
        .hall_r_nwr         (hall_r_nwr),
        .hall_request_floor (hall_request_floor),
        .hall_up_lamp       (hall_up_lamp),
        .hall_dn_lamp       (hall_dn_lamp),
        .pending_count      (pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hall_up_btn = '0;
        hall_dn_btn = '0;
        car_current_floor = 3'd7;
        car_dir = 1'b0;
        car_queue_empty = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Tick n times after a press edge (t=0); log each strobe with its tick index and floor.
    task automatic capture(input int n);
        st_t.delete();
        st_f.delete();
        for (int t = 1; t <= n; t++) begin
            tick();
            if (hall_r_nwr) begin
                st_t.push_back(t);
                st_f.push_back(int'(hall_request_floor));
            end
        end
    endtask

    task automatic press(input logic [6:0] up, input logic [6:0] dn);
        hall_up_btn = up;
        hall_dn_btn = dn;
        tick();
        hall_up_btn = '0;
        hall_dn_btn = '0;
    endtask

    initial begin
        do_reset();
        check("rst_up_lamp", 32'(hall_up_lamp), 32'h0);
        check("rst_dn_lamp", 32'(hall_dn_lamp), 32'h0);
        check("rst_strobe", 32'(hall_r_nwr), 32'h0);
        check("rst_floor", 32'(hall_request_floor), 32'h0);
        check("rst_count", 32'(pending_count), 32'h0);

        // Single up call at floor 3.
        press(7'h08, 7'h00);
        check("s1_lamp", 32'(hall_up_lamp), 32'h08);
        check("s1_count", 32'(pending_count), 32'd1);
        check("s1_no_early", 32'(hall_r_nwr), 32'h0);
        capture(50);
        check("s1_nstrobe", 32'(st_t.size()), 32'd1);
        check("s1_t", 32'(st_t.size() > 0 ? st_t[0] : -1), 32'd2);
        check("s1_f", 32'(st_f.size() > 0 ? st_f[0] : -1), 32'd3);
        check("s1_lamp_hold", 32'(hall_up_lamp), 32'h08);

        // Three calls at once: round-robin from pointer 0, spaced HOLDOFF+2.
        do_reset();
        press(7'h42, 7'h20);
        check("s2_count", 32'(pending_count), 32'd3);
        capture(30);
        check("s2_nstrobe", 32'(st_t.size()), 32'd3);
        if (st_t.size() == 3) begin
            check("s2_f0", 32'(st_f[0]), 32'd1);
            check("s2_f1", 32'(st_f[1]), 32'd5);
            check("s2_f2", 32'(st_f[2]), 32'd6);
            check("s2_t0", 32'(st_t[0]), 32'd2);
            check("s2_t1", 32'(st_t[1]), 32'd6);
            check("s2_t2", 32'(st_t[2]), 32'd10);
        end

        // Retire up[2] only when the car is heading up.
        do_reset();
        press(7'h04, 7'h00);
        capture(6);
        check("s3_f", 32'(st_f.size() > 0 ? st_f[0] : -1), 32'd2);
        car_current_floor = 3'd2;
        car_dir = 1'b0;
        car_queue_empty = 1'b0;
        tick();
        tick();
        check("s3_keep", 32'(hall_up_lamp), 32'h04);
        check("s3_keep_cnt", 32'(pending_count), 32'd1);
        car_dir = 1'b1;
        tick();
        check("s3_clear", 32'(hall_up_lamp), 32'h00);
        check("s3_clear_cnt", 32'(pending_count), 32'd0);
        car_current_floor = 3'd7;

        // Un-issued dn[4] survives the car at floor 4 until it is issued.
        do_reset();
        press(7'h02, 7'h10);
        tick();
        tick();
        check("s4_strobe1", 32'(hall_request_floor), 32'd1);
        tick();
        car_current_floor = 3'd4;
        car_queue_empty = 1'b1;
        tick();
        tick();
        check("s4_no_retire", 32'(hall_dn_lamp), 32'h10);
        tick();
        check("s4_strobe2", 32'(hall_r_nwr), 32'd1);
        check("s4_strobe2_f", 32'(hall_request_floor), 32'd4);
        check("s4_still_lit", 32'(hall_dn_lamp), 32'h10);
        tick();
        check("s4_retired", 32'(hall_dn_lamp), 32'h00);
        check("s4_up_kept", 32'(hall_up_lamp), 32'h02);
        check("s4_count", 32'(pending_count), 32'd1);
        car_current_floor = 3'd7;
        car_queue_empty = 1'b0;

        // Press and retire of up[0] on the same edge: lamp stays, one re-issue follows.
        do_reset();
        press(7'h01, 7'h00);
        capture(5);
        check("s5_first_f", 32'(st_f.size() > 0 ? st_f[0] : -1), 32'd0);
        car_current_floor = 3'd0;
        car_dir = 1'b1;
        hall_up_btn = 7'h01;
        tick();
        hall_up_btn = '0;
        car_current_floor = 3'd7;
        check("s5_lamp", 32'(hall_up_lamp), 32'h01);
        check("s5_count", 32'(pending_count), 32'd1);
        capture(20);
        check("s5_nstrobe", 32'(st_t.size()), 32'd1);
        check("s5_t", 32'(st_t.size() > 0 ? st_t[0] : -1), 32'd2);
        check("s5_f", 32'(st_f.size() > 0 ? st_f[0] : -1), 32'd0);

        // Asynchronous reset while the strobe is high.
        do_reset();
        press(7'h08, 7'h00);
        tick();
        tick();
        check("s6_strobe", 32'(hall_r_nwr), 32'd1);
        reset = 1'b1;
        #1;
        check("s6_async", 32'(hall_r_nwr), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("s6_up_lamp", 32'(hall_up_lamp), 32'h00);
        check("s6_count", 32'(pending_count), 32'd0);
        press(7'h20, 7'h00);
        capture(10);
        check("s6_nstrobe", 32'(st_t.size()), 32'd1);
        check("s6_t", 32'(st_t.size() > 0 ? st_t[0] : -1), 32'd2);
        check("s6_f", 32'(st_f.size() > 0 ? st_f[0] : -1), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
